// File: rtl/mxint_dequant.sv
// MXINT block dequantizer: shared-exponent mantissas to saturated fixed point.
// Two registered stages with valid/ready backpressure and a per-beat saturation flag.
module mxint_dequant #(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 2,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 2,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_OUT_0_PRECISION_1      = 4,
  localparam int MW = DATA_IN_0_PRECISION_0,
  localparam int EW = DATA_IN_0_PRECISION_1,
  localparam int BS = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1,
  localparam int OW = DATA_OUT_0_PRECISION_0,
  localparam int OF = DATA_OUT_0_PRECISION_1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MW*BS-1:0] mdata_in_0,
  input  logic [EW-1:0]    edata_in_0,
  input  logic             data_in_0_valid,
  output logic             data_in_0_ready,
  output logic [OW*BS-1:0] data_out_0,
  output logic             data_out_0_sat,
  output logic             data_out_0_valid,
  input  logic             data_out_0_ready
);

  localparam int SW = EW + $clog2(MW + OW + OF) + 1;
  localparam int WW = MW + OW + 1;
  localparam logic signed [WW-1:0] OMAX = WW'((1 << (OW - 1)) - 1);
  localparam logic signed [WW-1:0] OMIN = ~OMAX;

  if (OF >= OW) begin : g_bad_of
    $error("mxint_dequant: OF must be below OW");
  end
  if (MW < 2) begin : g_bad_mw
    $error("mxint_dequant: MW must be at least 2");
  end
  if (EW < 2) begin : g_bad_ew
    $error("mxint_dequant: EW must be at least 2");
  end

  // Returns {sat, value} for one mantissa scaled by 2^s.
  function automatic logic [OW:0] deq(
    input logic signed [MW-1:0] m,
    input logic signed [SW-1:0] s
  );
    logic signed [WW-1:0] w;
    logic signed [SW-1:0] ns;
    logic                 big;
    logic [OW:0]          r;
    w   = {{(WW-MW){m[MW-1]}}, m};
    ns  = -s;
    big = 1'b0;
    if (!s[SW-1]) begin
      if (s >= SW'(OW)) big = 1'b1;
      else              w = w <<< s;
    end else begin
      if (ns >= SW'(MW)) w = w >>> MW;
      else               w = w >>> ns;
    end
    if (m == '0)        r = '0;
    else if (big)       r = m[MW-1] ? {1'b1, OMIN[OW-1:0]}
                                    : {1'b1, OMAX[OW-1:0]};
    else if (w > OMAX)  r = {1'b1, OMAX[OW-1:0]};
    else if (w < OMIN)  r = {1'b1, OMIN[OW-1:0]};
    else                r = {1'b0, w[OW-1:0]};
    return r;
  endfunction

  logic                 s1_valid_q, s1_valid_d;
  logic [MW*BS-1:0]     s1_mant_q, s1_mant_d;
  logic signed [SW-1:0] s1_shift_q, s1_shift_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [OW*BS-1:0]     s2_data_q, s2_data_d;
  logic                 s2_sat_q, s2_sat_d;

  logic                 s1_ready;
  logic                 in_fire;
  logic                 s1_fire;
  logic signed [SW-1:0] shift_in;
  logic [OW*BS-1:0]     elem_out;
  logic                 elem_sat;
  logic [OW:0]          elem_r;

  assign s1_ready        = !s2_valid_q || data_out_0_ready;
  assign data_in_0_ready = !s1_valid_q || s1_ready;
  assign in_fire         = data_in_0_valid && data_in_0_ready;
  assign s1_fire         = s1_valid_q && s1_ready;

  assign shift_in = {{(SW-EW){edata_in_0[EW-1]}}, edata_in_0}
                  + SW'(OF - MW + 1);

  always_comb begin
    elem_out = '0;
    elem_sat = 1'b0;
    elem_r   = '0;
    for (int i = 0; i < BS; i++) begin
      elem_r = deq(s1_mant_q[i*MW +: MW], s1_shift_q);
      elem_out[i*OW +: OW] = elem_r[OW-1:0];
      elem_sat = elem_sat | elem_r[OW];
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mant_d  = s1_mant_q;
    s1_shift_d = s1_shift_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_sat_d   = s2_sat_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_mant_d  = mdata_in_0;
      s1_shift_d = shift_in;
    end else if (s1_fire) begin
      s1_valid_d = 1'b0;
    end
    if (s1_fire) begin
      s2_valid_d = 1'b1;
      s2_data_d  = elem_out;
      s2_sat_d   = elem_sat;
    end else if (data_out_0_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mant_q  <= '0;
      s1_shift_q <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_sat_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mant_q  <= s1_mant_d;
      s1_shift_q <= s1_shift_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_sat_q   <= s2_sat_d;
    end
  end

  assign data_out_0       = s2_data_q;
  assign data_out_0_sat   = s2_sat_q;
  assign data_out_0_valid = s2_valid_q;

endmodule

// File: tb/tb_mxint_dequant.sv
// Bench for mxint_dequant: directed cases plus randomized traffic
// scored against an arithmetic reference model.
module tb_mxint_dequant;

  localparam int MW = 8;
  localparam int EW = 4;
  localparam int BS = 4;
  localparam int OW = 8;
  localparam int OF = 4;

  logic             clk;
  logic             rst;
  logic [MW*BS-1:0] mdata;
  logic [EW-1:0]    edata;
  logic             din_valid;
  logic             din_ready;
  logic [OW*BS-1:0] dout;
  logic             dout_sat;
  logic             dout_valid;
  logic             dout_ready;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  int cyc    = 0;
  logic [OW*BS:0] q[$];
  logic           stalled_prev = 1'b0;
  logic [OW*BS:0] held;

  mxint_dequant dut (
    .clk              (clk),
    .rst              (rst),
    .mdata_in_0       (mdata),
    .edata_in_0       (edata),
    .data_in_0_valid  (din_valid),
    .data_in_0_ready  (din_ready),
    .data_out_0       (dout),
    .data_out_0_sat   (dout_sat),
    .data_out_0_valid (dout_valid),
    .data_out_0_ready (dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // value = floor(m * 2^s) clamped to the signed OW-bit range
  function automatic logic [OW*BS:0] model(
    input logic [MW*BS-1:0] mant,
    input logic [EW-1:0]    e
  );
    logic [OW*BS:0] res;
    int s;
    longint m, v, d;
    logic [MW-1:0] mb;
    res = '0;
    s = int'($signed(e)) + OF - MW + 1;
    for (int i = 0; i < BS; i++) begin
      mb = mant[i*MW +: MW];
      m = longint'($signed(mb));
      if (s >= 0) begin
        v = m * (longint'(1) << s);
      end else begin
        d = longint'(1) << (-s);
        v = m / d;
        if (m < 0 && (m % d) != 0) v = v - 1;
      end
      if (v > 127) begin
        v = 127;
        res[OW*BS] = 1'b1;
      end else if (v < -128) begin
        v = -128;
        res[OW*BS] = 1'b1;
      end
      res[i*OW +: OW] = v[OW-1:0];
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Score the current cycle's handshakes, then advance one clock.
  task automatic tick();
    logic [OW*BS:0] ev;
    #1;
    if (rst) begin
      q.delete();
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) chk("hold", {dout_sat, dout}, held);
      if (dout_valid && dout_ready) begin
        chk("expected_pending", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          ev = q.pop_front();
          chk("data", dout, ev[OW*BS-1:0]);
          chk("sat", dout_sat, ev[OW*BS]);
        end
        n_out++;
      end
      if (din_valid && din_ready) q.push_back(model(mdata, edata));
      stalled_prev = dout_valid && !dout_ready;
      held = {dout_sat, dout};
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_chk(input logic [31:0] m, input logic [3:0] e,
                          input logic [31:0] eo, input logic es);
    dout_ready = 1'b1;
    mdata = m;
    edata = e;
    din_valid = 1'b1;
    chk("accept_ready", din_ready, 1'b1);
    tick();
    din_valid = 1'b0;
    chk("lat_cycle1_valid", dout_valid, 1'b0);
    tick();
    chk("lat_cycle2_valid", dout_valid, 1'b1);
    chk("dir_data", dout, eo);
    chk("dir_sat", dout_sat, es);
    tick();
  endtask

  initial begin
    int sent, n0, first, last;
    logic saw_low;
    rst = 1'b1;
    din_valid = 1'b0;
    dout_ready = 1'b1;
    mdata = '0;
    edata = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", dout_valid, 1'b0);
    chk("rst_data", dout, 32'h0);
    chk("rst_sat", dout_sat, 1'b0);
    chk("rst_ready", din_ready, 1'b1);

    send_chk(32'h0001C040, 4'h0, 32'h0000F808, 1'b0);
    send_chk(32'h007F8040, 4'h4, 32'h007F807F, 1'b1);
    send_chk(32'h007F8040, 4'h3, 32'h007F8040, 1'b0);
    send_chk(32'h7F8001FF, 4'h8, 32'h00FF00FF, 1'b0);

    // backpressure: six back-to-back beats, sink stalls cycles 3..6
    sent = 0;
    n0 = n_out;
    saw_low = 1'b0;
    mdata = $urandom;
    edata = 4'($urandom);
    for (int c = 0; c < 16; c++) begin
      dout_ready = !(c >= 3 && c <= 6);
      din_valid = (sent < 6);
      #1;
      if (!din_ready) saw_low = 1'b1;
      if (din_valid && din_ready) begin
        tick();
        sent++;
        mdata = $urandom;
        edata = 4'($urandom);
      end else begin
        tick();
      end
    end
    din_valid = 1'b0;
    chk("bp_ready_dropped", saw_low, 1'b1);
    chk("bp_beats_out", n_out - n0, 6);
    chk("bp_queue_empty", q.size(), 0);

    // full throughput: 16 beats, no bubbles at the output
    dout_ready = 1'b1;
    sent = 0;
    n0 = n_out;
    first = -1;
    last = -1;
    for (int c = 0; c < 24; c++) begin
      din_valid = (sent < 16);
      mdata = $urandom;
      edata = 4'($urandom);
      if (dout_valid) begin
        if (first < 0) first = c;
        last = c;
      end
      if (din_valid && din_ready) sent++;
      tick();
    end
    din_valid = 1'b0;
    chk("tp_beats_out", n_out - n0, 16);
    chk("tp_span", last - first + 1, 16);

    // reset with both stages full
    dout_ready = 1'b0;
    din_valid = 1'b1;
    sent = 0;
    for (int c = 0; c < 4 && sent < 2; c++) begin
      mdata = $urandom;
      edata = 4'($urandom);
      #1;
      if (din_ready) sent++;
      tick();
    end
    din_valid = 1'b0;
    chk("full_ready_low", din_ready, 1'b0);
    chk("full_valid", dout_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", dout_valid, 1'b0);
    chk("mid_rst_data", dout, 32'h0);
    chk("mid_rst_sat", dout_sat, 1'b0);
    chk("mid_rst_ready", din_ready, 1'b1);
    dout_ready = 1'b1;
    tick();
    chk("mid_rst_no_ghost", dout_valid, 1'b0);
    send_chk(32'h0001C040, 4'h0, 32'h0000F808, 1'b0);

    // randomized traffic with random sink stalls
    for (int c = 0; c < 400; c++) begin
      din_valid = ($urandom % 4) != 0;
      dout_ready = ($urandom % 3) != 0;
      mdata = $urandom;
      edata = 4'($urandom);
      tick();
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    chk("drain_empty", q.size(), 0);
    chk("drain_valid", dout_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
